// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback-port arbiter: FSM state
// encoding, default bus widths and the writeback mux select encoding.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Writeback mux select / last-served encoding
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the two sources (A = ALU, B = load) and the arbiter
// that owns the register-file write port.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_a;
  logic              lock_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              req_b;
  logic              lock_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              mux_sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;

  modport master (
    output req_a, lock_a, addr_a, data_a,
    output req_b, lock_b, addr_b, data_b,
    input  gnt_a, gnt_b, mux_sel, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req_a, lock_a, addr_a, data_a,
    input  req_b, lock_b, addr_b, data_b,
    output gnt_a, gnt_b, mux_sel, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/Mux_2_1.sv
// Generic 2:1 mux used on the writeback data path.
module Mux_2_1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Sel,
  output logic [W-1:0] Out
);
  assign Out = Sel ? B : A;
endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a
// bounded lock so a bursting owner cannot starve the other source.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int              HC_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_TOP = HC_W'(MAX_HOLD - 1);

  state_t            state, nxt;
  logic              last;
  logic [HC_W-1:0]   hold_cnt;
  logic              can_hold;
  logic              gnt_a, gnt_b, sel, busy;
  logic [DATA_W-1:0] mux_data;
  logic [ADDR_W-1:0] mux_addr;

  // With MAX_HOLD=1 this is constant 0, so lock never extends ownership
  assign can_hold = (hold_cnt < HOLD_TOP);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) nxt = (last == SRC_A) ? GNT_B : GNT_A;
        else if (bus.req_a)         nxt = GNT_A;
        else if (bus.req_b)         nxt = GNT_B;
        else                        nxt = IDLE;
      end
      GNT_A: begin
        if (!bus.req_b && bus.req_a)                            nxt = GNT_A;
        else if (bus.req_b && bus.req_a && bus.lock_a && can_hold) nxt = GNT_A;
        else if (bus.req_b)                                     nxt = GNT_B;
        else                                                    nxt = IDLE;
      end
      GNT_B: begin
        if (!bus.req_a && bus.req_b)                            nxt = GNT_B;
        else if (bus.req_a && bus.req_b && bus.lock_b && can_hold) nxt = GNT_B;
        else if (bus.req_a)                                     nxt = GNT_A;
        else                                                    nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Grant-side outputs are decoded from the next state so they register
  // alongside it and always match the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= SRC_B;
      hold_cnt <= '0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= SRC_A;
      busy     <= 1'b0;
    end else begin
      state <= nxt;
      gnt_a <= (nxt == GNT_A);
      gnt_b <= (nxt == GNT_B);
      sel   <= (nxt == GNT_B) ? SRC_B : SRC_A;
      busy  <= (nxt != IDLE);
      if (state != IDLE && nxt != state)
        last <= (state == GNT_B) ? SRC_B : SRC_A;
      if (state != IDLE && nxt == state)
        hold_cnt <= can_hold ? hold_cnt + HC_W'(1) : hold_cnt;
      else
        hold_cnt <= '0;
    end
  end

  Mux_2_1 #(.W(DATA_W)) u_data_mux (
    .A  (bus.data_a),
    .B  (bus.data_b),
    .Sel(sel),
    .Out(mux_data)
  );

  assign mux_addr = (sel == SRC_B) ? bus.addr_b : bus.addr_a;

  assign bus.gnt_a   = gnt_a;
  assign bus.gnt_b   = gnt_b;
  assign bus.mux_sel = sel;
  assign bus.busy    = busy;
  assign bus.wr_en   = (gnt_a & bus.req_a) | (gnt_b & bus.req_b);
  assign bus.wr_addr = busy ? mux_addr : '0;
  assign bus.wr_data = busy ? mux_data : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: MAX_HOLD=4 instance under full check,
// MAX_HOLD=1 instance on shared stimulus with its grants checked where noted.
module tb_wb_port_arbiter;
  localparam logic [4:0]  A_ADDR = 5'd3;
  localparam logic [31:0] A_DATA = 32'hDEADBEEF;
  localparam logic [4:0]  B_ADDR = 5'd9;
  localparam logic [31:0] B_DATA = 32'hCAFE0001;

  typedef struct packed {
    logic        gnt_a;
    logic        gnt_b;
    logic        mux_sel;
    logic        wr_en;
    logic        busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        h1a;
    logic        h1b;
    logic        chk1;
  } obs_t;

  logic clk, rst;
  int   total = 0;
  int   bad   = 0;
  obs_t q[$];

  wb_port_arbiter_if if0 ();
  wb_port_arbiter_if if1 ();

  assign if1.req_a  = if0.req_a;
  assign if1.lock_a = if0.lock_a;
  assign if1.addr_a = if0.addr_a;
  assign if1.data_a = if0.data_a;
  assign if1.req_b  = if0.req_b;
  assign if1.lock_b = if0.lock_b;
  assign if1.addr_b = if0.addr_b;
  assign if1.data_b = if0.data_b;

  wb_port_arbiter #(.MAX_HOLD(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  wb_port_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // st: 0=IDLE 1=A owns 2=B owns; h1: grant of the MAX_HOLD=1 copy, -1 = unchecked
  function automatic obs_t mk(input int st, input logic we, input int h1);
    obs_t e;
    e         = '0;
    e.gnt_a   = (st == 1);
    e.gnt_b   = (st == 2);
    e.mux_sel = (st == 2);
    e.busy    = (st != 0);
    e.wr_en   = we;
    if (st == 1) begin e.wr_addr = A_ADDR; e.wr_data = A_DATA; end
    if (st == 2) begin e.wr_addr = B_ADDR; e.wr_data = B_DATA; end
    e.h1a  = (h1 == 1);
    e.h1b  = (h1 == 2);
    e.chk1 = (h1 >= 0);
    return e;
  endfunction

  task automatic check(input string tag);
    obs_t e, o;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e         = q.pop_front();
      o.gnt_a   = if0.gnt_a;
      o.gnt_b   = if0.gnt_b;
      o.mux_sel = if0.mux_sel;
      o.wr_en   = if0.wr_en;
      o.busy    = if0.busy;
      o.wr_addr = if0.wr_addr;
      o.wr_data = if0.wr_data;
      o.h1a     = e.chk1 ? if1.gnt_a : e.h1a;
      o.h1b     = e.chk1 ? if1.gnt_b : e.h1b;
      o.chk1    = e.chk1;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  // Push expectation, advance one edge, compare away from the edge
  task automatic cyc(input string tag, input obs_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Compare combinational outputs mid-cycle after an input change
  task automatic now(input string tag, input obs_t e);
    q.push_back(e);
    #1;
    check(tag);
  endtask

  task automatic drv(input logic ra, la, rb, lb, r);
    if0.req_a  = ra;
    if0.lock_a = la;
    if0.req_b  = rb;
    if0.lock_b = lb;
    rst        = r;
  endtask

  initial begin
    if0.addr_a = A_ADDR;
    if0.data_a = A_DATA;
    if0.addr_b = B_ADDR;
    if0.data_b = B_DATA;

    // reset held with both requesting
    drv(1, 0, 1, 0, 1);
    cyc("rst0", mk(0, 0, 0));
    cyc("rst1", mk(0, 0, 0));
    drv(1, 0, 1, 0, 0);
    cyc("tie_a_after_rst", mk(1, 1, 1));
    drv(0, 0, 0, 0, 0);
    cyc("idle0", mk(0, 0, 0));

    // single source, three back-to-back writes
    drv(1, 0, 0, 0, 0);
    cyc("single0", mk(1, 1, 1));
    cyc("single1", mk(1, 1, 1));
    cyc("single2", mk(1, 1, 1));
    drv(0, 0, 0, 0, 0);
    cyc("idle1", mk(0, 0, 0));

    // contention without lock: last served was A, so B first
    drv(1, 0, 1, 0, 0);
    cyc("rr_b0", mk(2, 1, 2));
    cyc("rr_a0", mk(1, 1, 1));
    cyc("rr_b1", mk(2, 1, 2));
    cyc("rr_a1", mk(1, 1, 1));
    drv(0, 0, 0, 0, 0);
    cyc("idle2", mk(0, 0, 0));

    // locked burst: A holds 4 cycles, B takes the 5th
    drv(1, 1, 0, 0, 0);
    cyc("lock_a0", mk(1, 1, -1));
    drv(1, 1, 1, 0, 0);
    cyc("lock_a1", mk(1, 1, -1));
    cyc("lock_a2", mk(1, 1, -1));
    cyc("lock_a3", mk(1, 1, -1));
    cyc("lock_sw_b", mk(2, 1, -1));

    // owner drop inside GNT_B
    drv(0, 0, 0, 0, 0);
    now("drop_owned", mk(2, 0, -1));
    cyc("drop_idle", mk(0, 0, -1));

    // reset during the second locked A cycle
    drv(1, 1, 1, 0, 0);
    cyc("mid_a0", mk(1, 1, -1));
    cyc("mid_a1", mk(1, 1, -1));
    drv(1, 1, 1, 0, 1);
    cyc("mid_rst", mk(0, 0, 0));

    // after release: tie to A, full hold from a cleared counter;
    // MAX_HOLD=1 copy alternates strictly despite lock
    drv(1, 1, 1, 0, 0);
    cyc("post_a0", mk(1, 1, 1));
    cyc("post_a1", mk(1, 1, 2));
    cyc("post_a2", mk(1, 1, 1));
    cyc("post_a3", mk(1, 1, 2));
    cyc("post_sw_b", mk(2, 1, 1));
    drv(0, 0, 0, 0, 0);
    cyc("idle3", mk(0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
